// File: rtl/alu_nibble_seq_pkg.sv
// Shared types and sizes for the nibble-serial 16-bit adder (alu_nibble_seq).
package alu_seq_pkg;

  localparam int W     = 16;
  localparam int NIB   = W / 4;
  localparam int CNT_W = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/alu_nibble_seq_if.sv
// Operand/result handshake bundle for alu_nibble_seq.
// The sub signal exists only when ALU_SEQ_SUB_EN is defined.
interface alu_nibble_seq_if;
  import alu_seq_pkg::*;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
`ifdef ALU_SEQ_SUB_EN
  logic         sub;
`endif
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] s;
  logic         sign;
  logic         zero;
  logic         carry;
  logic         parity;
  logic         overflow;

  modport master (
`ifdef ALU_SEQ_SUB_EN
    output sub,
`endif
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, s, sign, zero, carry, parity, overflow
  );

  modport slave (
`ifdef ALU_SEQ_SUB_EN
    input  sub,
`endif
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, s, sign, zero, carry, parity, overflow
  );

endinterface

// File: rtl/alu_nibble_seq_nibble_add4.sv
// Combinational 4-bit adder slice with carry in/out; the only adder in alu_nibble_seq.
module nibble_add4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       cout
);

  logic [4:0] sum;

  assign sum  = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
  assign s    = sum[3:0];
  assign cout = sum[4];

endmodule

// File: rtl/alu_nibble_seq.sv
// 16-bit add (optionally subtract, ALU_SEQ_SUB_EN) computed LSB-first in four
// passes through one shared 4-bit slice, with registered result flags.
module alu_nibble_seq
  import alu_seq_pkg::*;
(
  input logic             clk,
  input logic             rst_n,
  alu_nibble_seq_if.slave bus
);

  localparam logic [1:0] S_IDLE = IDLE;
  localparam logic [1:0] S_RUN  = RUN;
  localparam logic [1:0] S_DONE = DONE;
  localparam logic [CNT_W-1:0] LAST_NIB = CNT_W'(NIB - 1);

  logic [1:0]       state;
  logic [CNT_W-1:0] nib_cnt;
  logic             carry_reg;
  logic [W-1:0]     a_reg;
  logic [W-1:0]     b_reg;
  logic [W-1:0]     s_reg;
  logic             sign_reg;
  logic             zero_reg;
  logic             carry_flag;
  logic             parity_reg;
  logic             ovf_reg;

  logic             take;
  logic             sub_req;
  logic [3:0]       slice_a;
  logic [3:0]       slice_b;
  logic [3:0]       slice_s;
  logic             slice_cout;
  logic [W-1:0]     s_next;

  function automatic logic parity_even(input logic [W-1:0] v);
    return ~^v;
  endfunction

  function automatic logic add_overflow(input logic a_msb, input logic b_msb,
                                        input logic s_msb);
    return (a_msb & b_msb & ~s_msb) | (~a_msb & ~b_msb & s_msb);
  endfunction

`ifdef ALU_SEQ_SUB_EN
  assign sub_req = bus.sub;
`else
  assign sub_req = 1'b0;
`endif

  assign take = bus.in_valid && (state == S_IDLE);

  // b_reg already holds the inverted operand when subtracting
  assign slice_a = a_reg[{nib_cnt, 2'b00} +: 4];
  assign slice_b = b_reg[{nib_cnt, 2'b00} +: 4];

  nibble_add4 u_slice (
    .a    (slice_a),
    .b    (slice_b),
    .cin  (carry_reg),
    .s    (slice_s),
    .cout (slice_cout)
  );

  always_comb begin
    s_next = s_reg;
    s_next[{nib_cnt, 2'b00} +: 4] = slice_s;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      nib_cnt    <= '0;
      carry_reg  <= 1'b0;
      a_reg      <= '0;
      b_reg      <= '0;
      s_reg      <= '0;
      sign_reg   <= 1'b0;
      zero_reg   <= 1'b0;
      carry_flag <= 1'b0;
      parity_reg <= 1'b0;
      ovf_reg    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (take) begin
            a_reg     <= bus.a;
            b_reg     <= sub_req ? ~bus.b : bus.b;
            carry_reg <= sub_req;
            nib_cnt   <= '0;
            state     <= S_RUN;
          end
        end
        S_RUN: begin
          s_reg     <= s_next;
          carry_reg <= slice_cout;
          nib_cnt   <= nib_cnt + 1'b1;
          if (nib_cnt == LAST_NIB) begin
            sign_reg   <= s_next[W-1];
            zero_reg   <= ~|s_next;
            carry_flag <= slice_cout;
            parity_reg <= parity_even(s_next);
            ovf_reg    <= add_overflow(a_reg[W-1], b_reg[W-1], s_next[W-1]);
            state      <= S_DONE;
          end
        end
        S_DONE: begin
          if (bus.out_ready) begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state == S_IDLE);
  assign bus.out_valid = (state == S_DONE);
  assign bus.s         = s_reg;
  assign bus.sign      = sign_reg;
  assign bus.zero      = zero_reg;
  assign bus.carry     = carry_flag;
  assign bus.parity    = parity_reg;
  assign bus.overflow  = ovf_reg;

endmodule

// File: tb/tb_alu_nibble_seq.sv
// Directed bench for alu_nibble_seq; subtraction vectors run when ALU_SEQ_SUB_EN is defined.
module tb_alu_nibble_seq;
  import alu_seq_pkg::*;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  alu_nibble_seq_if bus ();

  alu_nibble_seq dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // flags packed as {sign, zero, carry, parity, overflow}
  function automatic logic [4:0] flags();
    return {bus.sign, bus.zero, bus.carry, bus.parity, bus.overflow};
  endfunction

  task automatic wait_ready(input string tag);
    int n;
    n = 0;
    while (!bus.in_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_ready_timeout"}, 32'(bus.in_ready), 32'd1);
  endtask

  task automatic drive_sub(input logic sb);
`ifdef ALU_SEQ_SUB_EN
    bus.sub = sb;
`else
    if (sb) $display("note: sub request ignored in add-only build");
`endif
  endtask

  // Issue one op, wait for out_valid, check latency and result; no handshake here.
  task automatic run_op(input string tag, input logic [15:0] av, input logic [15:0] bv,
                        input logic sb, input logic [15:0] es, input logic [4:0] ef);
    int lat;
    wait_ready(tag);
    bus.in_valid = 1'b1;
    bus.a        = av;
    bus.b        = bv;
    drive_sub(sb);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.a        = 16'($urandom);
    bus.b        = 16'($urandom);
    drive_sub(1'b0);
    lat = 0;
    while (!bus.out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_latency"}, 32'(lat), 32'd4);
    check({tag, "_s"},       32'(bus.s), 32'(es));
    check({tag, "_flags"},   32'(flags()), 32'(ef));
  endtask

  task automatic handshake(input string tag);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    check({tag, "_hs_out_valid"}, 32'(bus.out_valid), 32'd0);
    check({tag, "_hs_in_ready"},  32'(bus.in_ready),  32'd1);
  endtask

  initial begin
    logic [15:0] held_s;
    logic [4:0]  held_f;
    n_checks      = 0;
    n_errors      = 0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.out_ready = 1'b1;
    drive_sub(1'b0);
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready",  32'(bus.in_ready),  32'd1);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_s",         32'(bus.s),         32'd0);
    check("rst_flags",     32'(flags()),       32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_op("add_1234", 16'h1234, 16'h4321, 1'b0, 16'h5555, 5'b00010);
    handshake("add_1234");
    run_op("wrap",     16'hFFFF, 16'h0001, 1'b0, 16'h0000, 5'b01110);
    handshake("wrap");
    run_op("ovf",      16'h7FFF, 16'h0001, 1'b0, 16'h8000, 5'b10001);
    handshake("ovf");

    // Stall in DONE with a competing request that must be ignored
    bus.out_ready = 1'b0;
    run_op("stall", 16'h00FF, 16'h0001, 1'b0, 16'h0100, 5'b00000);
    held_s = bus.s;
    held_f = flags();
    for (int i = 0; i < 10; i++) begin
      bus.in_valid = (i == 3 || i == 4);
      bus.a        = 16'hAAAA;
      bus.b        = 16'h1111;
      @(posedge clk); #1;
      check("stall_s",         32'(bus.s),         32'(held_s));
      check("stall_flags",     32'(flags()),       32'(held_f));
      check("stall_out_valid", 32'(bus.out_valid), 32'd1);
      check("stall_in_ready",  32'(bus.in_ready),  32'd0);
    end
    bus.in_valid = 1'b0;
    handshake("stall");
    @(posedge clk); #1;
    check("stall_not_taken", 32'(bus.in_ready), 32'd1);
    run_op("after_stall", 16'h0001, 16'h0002, 1'b0, 16'h0003, 5'b00010);
    handshake("after_stall");

    // Reset asserted during the second RUN cycle
    bus.in_valid = 1'b1;
    bus.a        = 16'h1234;
    bus.b        = 16'h4321;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(posedge clk); #2;
    check("pre_rst_partial", 32'(bus.s[3:0]), 32'h5);
    rst_n = 1'b0;
    #1;
    check("mid_rst_in_ready",  32'(bus.in_ready),  32'd1);
    check("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("mid_rst_s",         32'(bus.s),         32'd0);
    check("mid_rst_flags",     32'(flags()),       32'd0);
    @(posedge clk); #3;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_out_valid", 32'(bus.out_valid), 32'd0);
    run_op("post_rst", 16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 5'b00000);
    handshake("post_rst");

`ifdef ALU_SEQ_SUB_EN
    run_op("sub_5_7",    16'h0005, 16'h0007, 1'b1, 16'hFFFE, 5'b10000);
    handshake("sub_5_7");
    run_op("sub_8000_1", 16'h8000, 16'h0001, 1'b1, 16'h7FFF, 5'b00101);
    handshake("sub_8000_1");
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
